// File: rtl/traffic_pkg.sv
// traffic_pkg: codes and default times shared by the light FSM and the interval timer.
package traffic_pkg;
  localparam logic [2:0] INT_BASE  = 3'd0;
  localparam logic [2:0] INT_EXT   = 3'd1;
  localparam logic [2:0] INT_YEL   = 3'd2;
  localparam logic [2:0] INT_BASE2 = 3'd3;
  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;
  localparam logic [3:0] T_BASE_DEF = 4'd6;
  localparam logic [3:0] T_EXT_DEF  = 4'd3;
  localparam logic [3:0] T_YEL_DEF  = 4'd2;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [3:0] nz(input logic [3:0] v);
    return v == 4'd0 ? 4'd1 : v;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: mod-TICK_DIV counter producing a one-cycle tick, held at zero by clear.
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/interval_timer.sv
// interval_timer: programmable one-second countdown returning a one-cycle expired pulse.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int         TICK_DIV   = 50_000_000,
  parameter logic [3:0] T_BASE_DEF = traffic_pkg::T_BASE_DEF,
  parameter logic [3:0] T_EXT_DEF  = traffic_pkg::T_EXT_DEF,
  parameter logic [3:0] T_YEL_DEF  = traffic_pkg::T_YEL_DEF
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic [2:0] interval,
  input  logic       start_timer,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  output logic       expired,
  output logic       busy,
  output logic [4:0] remaining
);
  state_t state, state_n;
  logic [3:0] t_base, t_ext, t_yel;
  logic [4:0] dur, rem_n;
  logic exp_n, tick;
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clk(clk), .Reset_n(Reset_n), .clear(start_timer || state == IDLE), .tick(tick)
  );
  // decode reads the registered params, so a same-cycle write only affects later starts
  assign dur = interval == INT_EXT   ? {1'b0, t_ext} :
               interval == INT_YEL   ? {1'b0, t_yel} :
               interval == INT_BASE2 ? {t_base, 1'b0} : {1'b0, t_base};
  assign busy = state == RUN;
  always_comb begin
    state_n = state;
    rem_n   = remaining;
    exp_n   = 1'b0;
    if (start_timer) begin
      state_n = RUN;
      rem_n   = dur;
    end else if (state == RUN && tick) begin
      rem_n   = remaining - 5'd1;
      exp_n   = remaining == 5'd1;
      state_n = remaining == 5'd1 ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      t_base    <= T_BASE_DEF;
      t_ext     <= T_EXT_DEF;
      t_yel     <= T_YEL_DEF;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      expired   <= exp_n;
      t_base    <= (Prog_Sync && Time_Param_Sel == SEL_BASE) ? nz(Time_Value) : t_base;
      t_ext     <= (Prog_Sync && Time_Param_Sel == SEL_EXT)  ? nz(Time_Value) : t_ext;
      t_yel     <= (Prog_Sync && Time_Param_Sel == SEL_YEL)  ? nz(Time_Value) : t_yel;
    end
endmodule
